// File: rtl/pong_pkg.sv
// Shared definitions for the Pong button-conditioning path: default channel
// count, default debounce/auto-repeat timing and the repeat FSM state type.
package pong_pkg;

   // Number of dedicated button inputs the game top routes to the conditioner.
   localparam int PONG_BTN_CHANNELS = 4;

   // Default time-base constants, all expressed in tick_en strobes.
   localparam int PONG_DEBOUNCE_TICKS = 16;
   localparam int PONG_REPEAT_DELAY   = 32;
   localparam int PONG_REPEAT_PERIOD  = 8;

   // Auto-repeat sequencing for one held button.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } repeat_state_t;

   // Larger of two integers, used to size the shared repeat counter.
   function automatic int pong_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pong_btn_channel.sv
// One button channel: two-flop synchroniser, tick-qualified debouncer that
// produces press/release pulses, and an auto-repeat FSM that emits step
// pulses while the debounced button stays held.
module pong_btn_channel
   import pong_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = PONG_DEBOUNCE_TICKS,
   parameter int REPEAT_DELAY   = PONG_REPEAT_DELAY,
   parameter int REPEAT_PERIOD  = PONG_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_en,
   input  logic raw,
   input  logic repeat_en,
   output logic level_out,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse
);

   // The debounce counter only ever needs to reach DEBOUNCE_TICKS-1; keep
   // at least one bit so a single-tick debounce still elaborates.
   localparam int DB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

   // The repeat counter is shared by the initial delay and the period, so it
   // must be able to represent the larger of the two terminal values.
   localparam int RP_MAX = pong_max(REPEAT_DELAY, REPEAT_PERIOD);
   localparam int RP_W   = $clog2(RP_MAX + 1);
   localparam logic [RP_W-1:0] RP_DELAY_END  = RP_W'(REPEAT_DELAY);
   localparam logic [RP_W-1:0] RP_PERIOD_END = RP_W'(REPEAT_PERIOD);

   logic            sync_a;
   logic            s;
   logic            level;
   logic [DB_W-1:0] db_cnt;
   logic            db_done;
   logic            rise_evt;
   logic            fall_evt;

   repeat_state_t   state;
   repeat_state_t   next_state;
   logic [RP_W-1:0] rp_cnt;
   logic [RP_W-1:0] rp_next;
   logic [RP_W-1:0] rp_inc;
   logic            repeat_next;

   // Bring the asynchronous button into the clk domain through two flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= 1'b0;
         s      <= 1'b0;
      end else begin
         sync_a <= raw;
         s      <= sync_a;
      end
   end

   // The debounced level flips on the tick that completes a full run of
   // disagreeing ticks; these are the edge events both the pulse outputs
   // and the repeat FSM act on in the same cycle.
   assign db_done  = (s != level) && tick_en && (db_cnt == DB_LAST);
   assign rise_evt = db_done &  s;
   assign fall_evt = db_done & ~s;

   // Debounce: any cycle where the synchronised input agrees with the
   // current level restarts qualification, independent of the time base.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level  <= 1'b0;
         db_cnt <= '0;
      end else if (s == level) begin
         db_cnt <= '0;
      end else if (tick_en) begin
         if (db_cnt == DB_LAST) begin
            level  <= s;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   // Register the edge pulses so they are exactly one clk wide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= rise_evt;
         release_pulse <= fall_evt;
      end
   end

   assign level_out = level;
   assign rp_inc    = rp_cnt + RP_W'(1);

   // Repeat sequencing: a release always wins over a coincident terminal
   // count, and repeat_en only masks the pulse so the cadence continues
   // undisturbed when it is toggled mid-hold.
   always_comb begin
      next_state  = state;
      rp_next     = rp_cnt;
      repeat_next = 1'b0;
      case (state)
         IDLE: begin
            if (rise_evt) begin
               next_state = DELAY;
               rp_next    = '0;
            end
         end
         DELAY: begin
            if (fall_evt) begin
               next_state = IDLE;
               rp_next    = '0;
            end else if (tick_en) begin
               if (rp_inc == RP_DELAY_END) begin
                  repeat_next = repeat_en;
                  next_state  = REPEAT;
                  rp_next     = '0;
               end else begin
                  rp_next = rp_inc;
               end
            end
         end
         REPEAT: begin
            if (fall_evt) begin
               next_state = IDLE;
               rp_next    = '0;
            end else if (tick_en) begin
               if (rp_inc == RP_PERIOD_END) begin
                  repeat_next = repeat_en;
                  rp_next     = '0;
               end else begin
                  rp_next = rp_inc;
               end
            end
         end
         default: begin
            next_state = IDLE;
            rp_next    = '0;
         end
      endcase
   end

   // Repeat FSM state, counter and registered repeat pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rp_cnt       <= '0;
         repeat_pulse <= 1'b0;
      end else begin
         state        <= next_state;
         rp_cnt       <= rp_next;
         repeat_pulse <= repeat_next;
      end
   end

endmodule

// File: rtl/pong_input_conditioner.sv
// Multi-channel button conditioner between the ui_in button pins and the
// Pong game core. Every channel is an independent pong_btn_channel, so
// simultaneous events on different buttons are reported in the same cycle.
module pong_input_conditioner
   import pong_pkg::*;
#(
   parameter int CHANNELS       = PONG_BTN_CHANNELS,
   parameter int DEBOUNCE_TICKS = PONG_DEBOUNCE_TICKS,
   parameter int REPEAT_DELAY   = PONG_REPEAT_DELAY,
   parameter int REPEAT_PERIOD  = PONG_REPEAT_PERIOD
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick_en,
   input  logic [CHANNELS-1:0] raw_in,
   input  logic [CHANNELS-1:0] repeat_en,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] repeat_pulse
);

   // One conditioner per button; all share the clock, reset and time base.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      pong_btn_channel #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .tick_en       (tick_en),
         .raw           (raw_in[i]),
         .repeat_en     (repeat_en[i]),
         .level_out     (level_out[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .repeat_pulse  (repeat_pulse[i])
      );
   end

endmodule
